// File: rtl/wb_l2_responder.sv
// wb_l2_responder
//   Wishbone slave standing in for the L2 / physical memory at the far end
//   of the L1-to-L2 link. Serves 128-bit line reads and byte-masked line
//   writes from an internal line array with a fixed, parameterised latency.
//   Lines at or beyond DEPTH get a single-cycle retry and no array access.
//
// Parameters
//   LATENCY : cycles from the acceptance edge to the edge that samples ACK (1..15)
//   DEPTH   : number of 128-bit lines implemented (1..4096)
//
// Ports
//   CLK    in   clock, rising edge
//   RST    in   synchronous active-high reset (array contents are kept)
//   CYC    in   bus cycle in progress
//   STB    in   request strobe
//   WE     in   1 = line write, 0 = line read
//   SEL    in   [15:0]  byte enables, bit i covers DAT_M[8i+7:8i]
//   ADR    in   [11:0]  line address
//   DAT_M  in   [127:0] write data from master
//   DAT_S  out  [127:0] registered read data, valid in the ACK cycle
//   ACK    out  one-cycle completion pulse
//   RTY    out  one-cycle retry pulse for out-of-range lines
//
// Transaction flow: IDLE -> WAIT (counting) -> RESP (ACK) -> RECOVER -> IDLE,
// or IDLE -> RECOVER (RTY) for an out-of-range line. RECOVER ignores the bus
// so a master that keeps STB high after ACK/RTY is not served twice.

module wb_l2_responder #(
  parameter int LATENCY = 4,
  parameter int DEPTH   = 256
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         CYC,
  input  logic         STB,
  input  logic         WE,
  input  logic [15:0]  SEL,
  input  logic [11:0]  ADR,
  input  logic [127:0] DAT_M,
  output logic [127:0] DAT_S,
  output logic         ACK,
  output logic         RTY
);

  localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);
  localparam logic [12:0] DEPTH_W  = 13'(DEPTH);
  localparam bit          LAT_ONE  = (LATENCY == 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAIT    = 2'd1;
  localparam logic [1:0] ST_RESP    = 2'd2;
  localparam logic [1:0] ST_RECOVER = 2'd3;

  logic [1:0]    r_state;
  logic [3:0]    r_cnt;
  logic [AW-1:0] r_idx;
  logic          r_we;
  logic [15:0]   r_sel;
  logic [127:0]  r_dat_m;
  logic          r_ack;
  logic          r_rty;
  logic [127:0]  r_dat_s;

  logic [127:0]  r_mem [DEPTH];

  logic          w_req;
  logic          w_in_range;
  logic          w_rd_en;
  logic [AW-1:0] w_rd_idx;
  logic          w_wr_en;

  assign w_req      = CYC && STB;
  assign w_in_range = ({1'b0, ADR} < DEPTH_W);

  // The line is read into DAT_S on the edge that enters RESP. With a
  // one-cycle latency that edge is the acceptance edge itself, so the
  // address must come straight from the bus instead of the capture register.
  always_comb begin
    w_rd_en  = 1'b0;
    w_rd_idx = r_idx;
    if (r_state == ST_IDLE) begin
      w_rd_idx = ADR[AW-1:0];
      w_rd_en  = LAT_ONE && w_req && w_in_range && !WE;
    end else if (r_state == ST_WAIT) begin
      w_rd_en  = CYC && (r_cnt == 4'd1) && !r_we;
    end
  end

  // Write commits on the edge that ends the ACK cycle; a reset on that same
  // edge discards it.
  assign w_wr_en = (r_state == ST_RESP) && r_we && !RST;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_ack   <= 1'b0;
      r_rty   <= 1'b0;
      r_dat_s <= '0;
    end else begin
      r_ack <= 1'b0;
      r_rty <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            r_idx   <= ADR[AW-1:0];
            r_we    <= WE;
            r_sel   <= SEL;
            r_dat_m <= DAT_M;
            if (!w_in_range) begin
              r_state <= ST_RECOVER;
              r_rty   <= 1'b1;
            end else if (LAT_ONE) begin
              r_state <= ST_RESP;
              r_ack   <= 1'b1;
            end else begin
              r_state <= ST_WAIT;
              r_cnt   <= CNT_LOAD;
            end
          end
        end
        ST_WAIT: begin
          if (!CYC) begin
            // Master abandoned the cycle: no ACK and no write.
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
            if (r_cnt == 4'd1) begin
              r_state <= ST_RESP;
              r_ack   <= 1'b1;
            end
          end
        end
        ST_RESP: begin
          r_state <= ST_RECOVER;
        end
        ST_RECOVER: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
      if (w_rd_en) begin
        r_dat_s <= r_mem[w_rd_idx];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (w_wr_en) begin
      for (int i = 0; i < 16; i++) begin
        if (r_sel[i]) begin
          r_mem[r_idx][8*i +: 8] <= r_dat_m[8*i +: 8];
        end
      end
    end
  end

  assign ACK   = r_ack;
  assign RTY   = r_rty;
  assign DAT_S = r_dat_s;

endmodule

// File: tb/tb_wb_l2_responder.sv
// Directed, scoreboard-based bench for wb_l2_responder (LATENCY=4, DEPTH=256).
// Each request pushes its expected response (kind, edge index, read data)
// into a queue; the per-cycle monitor pops and compares on every ACK/RTY.

module tb_wb_l2_responder;

  localparam int LAT = 4;
  localparam int DEP = 256;

  logic         CLK = 1'b0;
  logic         RST;
  logic         CYC;
  logic         STB;
  logic         WE;
  logic [15:0]  SEL;
  logic [11:0]  ADR;
  logic [127:0] DAT_M;
  logic [127:0] DAT_S;
  logic         ACK;
  logic         RTY;

  wb_l2_responder #(.LATENCY(LAT), .DEPTH(DEP)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .CYC   (CYC),
    .STB   (STB),
    .WE    (WE),
    .SEL   (SEL),
    .ADR   (ADR),
    .DAT_M (DAT_M),
    .DAT_S (DAT_S),
    .ACK   (ACK),
    .RTY   (RTY)
  );

  always #5 CLK = ~CLK;

  int unsigned edge_n = 0;
  always @(posedge CLK) edge_n <= edge_n + 1;

  typedef struct {
    bit           is_rty;
    bit           is_read;
    logic [127:0] data;
    int unsigned  at_edge;
  } sb_t;

  sb_t          sb[$];
  logic [127:0] mdl [4096];
  logic [127:0] last_read;
  int           n_checks = 0;
  int           n_fail   = 0;
  int           n_ack    = 0;
  bit           resp_seen;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Samples the current cycle at the falling edge, then advances past the
  // next rising edge; inputs are changed by callers 1 time unit after it.
  task automatic tick();
    sb_t e;
    @(negedge CLK);
    n_checks++;
    assert (!(ACK && RTY)) else begin
      n_fail++;
      $error("FAIL ack_rty_exclusive: observed ACK=%b RTY=%b expected not both", ACK, RTY);
    end
    if (ACK || RTY) begin
      n_checks++;
      assert (sb.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_resp: observed ACK=%b RTY=%b at edge %0d expected none", ACK, RTY, edge_n);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("resp_is_rty", {127'd0, RTY}, {127'd0, e.is_rty});
        chk("resp_edge", 128'(edge_n), 128'(e.at_edge));
        if (ACK && e.is_read) begin
          chk("read_data", DAT_S, e.data);
          last_read = e.data;
        end else begin
          chk("dat_s_hold", DAT_S, last_read);
        end
        if (ACK) n_ack++;
        resp_seen = 1'b1;
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic push_exp(input bit we, input logic [15:0] sel, input logic [11:0] adr,
                          input logic [127:0] dat, input int unsigned at_ack);
    sb_t e;
    e.is_rty  = (int'(adr) >= DEP);
    e.is_read = !we;
    e.data    = e.is_rty ? 128'd0 : mdl[adr];
    e.at_edge = e.is_rty ? edge_n + 1 : at_ack;
    sb.push_back(e);
    if (we && !e.is_rty) begin
      for (int i = 0; i < 16; i++) begin
        if (sel[i]) mdl[adr][8*i +: 8] = dat[8*i +: 8];
      end
    end
  endtask

  task automatic drive(input bit we, input logic [15:0] sel, input logic [11:0] adr,
                       input logic [127:0] dat);
    CYC = 1'b1; STB = 1'b1; WE = we; SEL = sel; ADR = adr; DAT_M = dat;
  endtask

  task automatic release_bus();
    CYC = 1'b0; STB = 1'b0; WE = 1'b0; SEL = '0; ADR = '0; DAT_M = '0;
  endtask

  // Standard master: hold the request until ACK/RTY, then release.
  task automatic wb_req(input bit we, input logic [15:0] sel, input logic [11:0] adr,
                        input logic [127:0] dat);
    push_exp(we, sel, adr, dat, edge_n + LAT);
    drive(we, sel, adr, dat);
    resp_seen = 1'b0;
    for (int k = 0; k < 40 && !resp_seen; k++) tick();
    n_checks++;
    assert (resp_seen) else begin
      n_fail++;
      $error("FAIL resp_timeout: observed no response expected one for adr %h", adr);
    end
    release_bus();
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

  localparam logic [127:0] D1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] P0 = 128'hDEADBEEF_0BADF00D_CAFEBABE_12345678;
  localparam logic [127:0] D3 = 128'hA5A5A5A5_5A5A5A5A_01234567_89ABCDEF;
  localparam logic [127:0] DL = 128'h0F0E0D0C_0B0A0908_07060504_03020100;

  initial begin
    int a0;
    for (int i = 0; i < 4096; i++) mdl[i] = '0;
    last_read = '0;
    RST = 1'b1;
    release_bus();
    @(posedge CLK); #1;

    // Reset state
    repeat (3) tick();
    RST = 1'b0;
    chk("reset_ack", {127'd0, ACK}, 128'd0);
    chk("reset_rty", {127'd0, RTY}, 128'd0);
    chk("reset_dat_s", DAT_S, 128'd0);
    tick();

    // Known contents for lines used later
    wb_req(1'b1, 16'hFFFF, 12'h000, P0);
    wb_req(1'b1, 16'hFFFF, 12'h020, 128'd0);

    // Full-line write then read back
    wb_req(1'b1, 16'hFFFF, 12'h010, D1);
    wb_req(1'b0, 16'h0000, 12'h010, 128'd0);

    // Partial write of byte 0 only
    wb_req(1'b1, 16'h0001, 12'h010, {16{8'h5A}});
    wb_req(1'b0, 16'h0000, 12'h010, 128'd0);

    // SEL=0 write is a no-op that still ACKs
    wb_req(1'b1, 16'h0000, 12'h010, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF);
    wb_req(1'b0, 16'h0000, 12'h010, 128'd0);

    // Last in-range line and out-of-range lines
    wb_req(1'b1, 16'hFFFF, 12'h0FF, DL);
    wb_req(1'b0, 16'h0000, 12'h0FF, 128'd0);
    wb_req(1'b1, 16'hFFFF, 12'h100, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF);
    wb_req(1'b0, 16'h0000, 12'hFFF, 128'd0);
    wb_req(1'b0, 16'h0000, 12'h000, 128'd0);

    // Abort: drop CYC in the 2nd WAIT cycle; no ACK may follow
    a0 = n_ack;
    drive(1'b0, 16'h0000, 12'h010, 128'd0);
    tick();
    tick();
    release_bus();
    repeat (LAT + 3) tick();
    chk("abort_no_ack", 128'(n_ack), 128'(a0));
    wb_req(1'b0, 16'h0000, 12'h010, 128'd0);

    // Held strobe: two acceptances spaced LAT+2 edges apart, one ACK each
    a0 = n_ack;
    push_exp(1'b1, 16'hFFFF, 12'h030, D3, edge_n + LAT);
    push_exp(1'b1, 16'hFFFF, 12'h030, D3, edge_n + 2 * LAT + 2);
    drive(1'b1, 16'hFFFF, 12'h030, D3);
    repeat (2 * (LAT + 2)) tick();
    release_bus();
    repeat (3) tick();
    chk("held_ack_count", 128'(n_ack - a0), 128'd2);
    chk("held_sb_empty", 128'(sb.size()), 128'd0);
    wb_req(1'b0, 16'h0000, 12'h030, 128'd0);

    // Reset during WAIT of a write: no ACK, line unchanged, DAT_S cleared
    a0 = n_ack;
    drive(1'b1, 16'hFFFF, 12'h020, {16{8'hFF}});
    tick();
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    release_bus();
    last_read = '0;
    chk("rst_mid_ack", {127'd0, ACK}, 128'd0);
    chk("rst_mid_dat_s", DAT_S, 128'd0);
    repeat (LAT + 3) tick();
    chk("rst_mid_no_ack", 128'(n_ack), 128'(a0));
    wb_req(1'b0, 16'h0000, 12'h020, 128'd0);

    chk("final_sb_empty", 128'(sb.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
